// File: rtl/cordiv_is_mc.sv
// Multi-lane in-stream correlated divider: per-lane counter regeneration feeding a CORDIV kernel.
// Optional macro CORDIV_IS_SAT_EN: counters saturate instead of wrapping modulo 2^BW.
module cordiv_is_mc #(
  parameter int unsigned BW     = 8,
  parameter int unsigned DEP    = 2,
  parameter int unsigned DEPLOG = 1,
  parameter int unsigned CH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bipolar,
  input  logic                 in_valid,
  input  logic [CH*BW-1:0]     randNum,
  input  logic [CH*DEPLOG-1:0] randNumKernel,
  input  logic [CH-1:0]        dividend,
  input  logic [CH-1:0]        divisor,
  output logic [CH-1:0]        quotient,
  output logic                 out_valid
);

  localparam logic [BW-1:0] UNI_INIT = {1'b1, {(BW-1){1'b0}}};
  localparam logic [BW-1:0] BIP_INIT = '0;
`ifdef CORDIV_IS_SAT_EN
  localparam logic [BW-1:0] BIP_MAX  = {1'b0, {(BW-1){1'b1}}};
  localparam logic [BW-1:0] BIP_MIN  = {1'b1, {(BW-2){1'b0}}, 1'b1};
  localparam logic [BW-1:0] UNI_MAX  = '1;
  localparam logic [BW-1:0] UNI_MIN  = '0;

  // Saturating step; the bipolar range is kept symmetric so -2^(BW-1) never appears.
  function automatic logic [BW-1:0] cnt_step(input logic [BW-1:0] c, input logic up,
                                             input logic bip);
    logic [BW-1:0] lim;
    if (up) begin
      lim = bip ? BIP_MAX : UNI_MAX;
      cnt_step = (c == lim) ? c : c + BW'(1);
    end else begin
      lim = bip ? BIP_MIN : UNI_MIN;
      cnt_step = (c == lim) ? c : c - BW'(1);
    end
  endfunction
`else
  function automatic logic [BW-1:0] cnt_step(input logic [BW-1:0] c, input logic up);
    cnt_step = up ? c + BW'(1) : c - BW'(1);
  endfunction
`endif

  // Bipolar compares |cnt| against randNum/2; unipolar compares cnt against randNum directly.
  function automatic logic regen(input logic [BW-1:0] c, input logic [BW-1:0] r,
                                 input logic bip);
    logic [BW-1:0] mag;
    logic [BW-1:0] thr;
    mag   = (bip && c[BW-1]) ? (~c + BW'(1)) : c;
    thr   = bip ? (r >> 1) : r;
    regen = (mag > thr);
  endfunction

  logic                mode_q, mode_d;
  logic                out_valid_q, out_valid_d;
  logic [CH-1:0]       quotient_q, quotient_d;
  logic [BW-1:0]       cnt_dd_q [CH];
  logic [BW-1:0]       cnt_dd_d [CH];
  logic [BW-1:0]       cnt_ds_q [CH];
  logic [BW-1:0]       cnt_ds_d [CH];
  logic [DEP-1:0]      sr_q [CH];
  logic [DEP-1:0]      sr_d [CH];

  logic [BW-1:0]       lane_rn;
  logic [DEPLOG-1:0]   lane_idx;
  logic                dd_regen, ds_regen, dd_neg, ds_neg, kbit;

  // Next-state: mode change reinitialises, stall holds, accepted cycle advances each lane.
  always_comb begin
    mode_d      = bipolar;
    out_valid_d = 1'b0;
    quotient_d  = quotient_q;
    lane_rn     = '0;
    lane_idx    = '0;
    dd_regen    = 1'b0;
    ds_regen    = 1'b0;
    dd_neg      = 1'b0;
    ds_neg      = 1'b0;
    kbit        = 1'b0;
    for (int i = 0; i < CH; i++) begin
      cnt_dd_d[i] = cnt_dd_q[i];
      cnt_ds_d[i] = cnt_ds_q[i];
      sr_d[i]     = sr_q[i];
    end

    if (bipolar != mode_q) begin
      quotient_d = '0;
      for (int i = 0; i < CH; i++) begin
        cnt_dd_d[i] = bipolar ? BIP_INIT : UNI_INIT;
        cnt_ds_d[i] = bipolar ? BIP_INIT : UNI_INIT;
        sr_d[i]     = '0;
      end
    end else if (in_valid) begin
      out_valid_d = 1'b1;
      for (int i = 0; i < CH; i++) begin
        lane_rn  = randNum[i*BW +: BW];
        lane_idx = randNumKernel[i*DEPLOG +: DEPLOG];
        dd_regen = regen(cnt_dd_q[i], lane_rn, mode_q);
        ds_regen = regen(cnt_ds_q[i], lane_rn, mode_q);
        dd_neg   = mode_q & cnt_dd_q[i][BW-1];
        ds_neg   = mode_q & cnt_ds_q[i][BW-1];
        kbit     = ds_regen ? dd_regen : sr_q[i][lane_idx];
        if (ds_regen) begin
          sr_d[i] = {sr_q[i][DEP-2:0], dd_regen};
        end
        quotient_d[i] = kbit ^ dd_neg ^ ds_neg;
`ifdef CORDIV_IS_SAT_EN
        cnt_dd_d[i] = cnt_step(cnt_dd_q[i], dividend[i], mode_q);
        cnt_ds_d[i] = cnt_step(cnt_ds_q[i], divisor[i], mode_q);
`else
        cnt_dd_d[i] = cnt_step(cnt_dd_q[i], dividend[i]);
        cnt_ds_d[i] = cnt_step(cnt_ds_q[i], divisor[i]);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= bipolar;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      for (int i = 0; i < CH; i++) begin
        cnt_dd_q[i] <= bipolar ? BIP_INIT : UNI_INIT;
        cnt_ds_q[i] <= bipolar ? BIP_INIT : UNI_INIT;
        sr_q[i]     <= '0;
      end
    end else begin
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      for (int i = 0; i < CH; i++) begin
        cnt_dd_q[i] <= cnt_dd_d[i];
        cnt_ds_q[i] <= cnt_ds_d[i];
        sr_q[i]     <= sr_d[i];
      end
    end
  end

  assign quotient  = quotient_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cordiv_is_mc.sv
// Randomised bench for cordiv_is_mc against an integer-arithmetic model of the divider lanes.
module tb_cordiv_is_mc;
  localparam int unsigned BW = 8, DEP = 2, DEPLOG = 1, CH = 2;

  logic                 clk = 1'b0;
  logic                 rst, bipolar, in_valid;
  logic [CH*BW-1:0]     randNum;
  logic [CH*DEPLOG-1:0] randNumKernel;
  logic [CH-1:0]        dividend, divisor;
  logic [CH-1:0]        quotient;
  logic                 out_valid;

  cordiv_is_mc #(.BW(BW), .DEP(DEP), .DEPLOG(DEPLOG), .CH(CH)) dut (
    .clk(clk), .rst(rst), .bipolar(bipolar), .in_valid(in_valid),
    .randNum(randNum), .randNumKernel(randNumKernel),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: counters held as plain signed/unsigned integers in the current mode.
  int          m_dd [CH];
  int          m_ds [CH];
  bit          m_sr [CH][DEP];
  bit          m_mode;
  bit [CH-1:0] exp_q;
  bit          exp_v;

  function automatic int fix_range(input int v, input bit bip);
`ifdef CORDIV_IS_SAT_EN
    if (bip) return (v > 127) ? 127 : (v < -127) ? -127 : v;
    return (v > 255) ? 255 : (v < 0) ? 0 : v;
`else
    if (bip) return (v > 127) ? v - 256 : (v < -128) ? v + 256 : v;
    return (v > 255) ? v - 256 : (v < 0) ? v + 256 : v;
`endif
  endfunction

  function automatic bit m_regen(input int c, input int r, input bit bip);
    int a;
    a = (c < 0) ? -c : c;
    return bip ? (a > r / 2) : (c > r);
  endfunction

  task automatic model_reinit(input bit bip);
    for (int i = 0; i < CH; i++) begin
      m_dd[i] = bip ? 0 : 128;
      m_ds[i] = bip ? 0 : 128;
      for (int j = 0; j < DEP; j++) m_sr[i][j] = 1'b0;
    end
    m_mode = bip;
  endtask

  task automatic model_step();
    int r, idx;
    bit rd, rs, k;
    if (rst) begin
      model_reinit(bipolar);
      exp_q = '0; exp_v = 1'b0;
    end else if (bipolar != m_mode) begin
      model_reinit(bipolar);
      exp_q = '0; exp_v = 1'b0;
    end else if (!in_valid) begin
      exp_v = 1'b0;
    end else begin
      exp_v = 1'b1;
      for (int i = 0; i < CH; i++) begin
        r   = int'(randNum[i*BW +: BW]);
        idx = int'(randNumKernel[i*DEPLOG +: DEPLOG]);
        rd  = m_regen(m_dd[i], r, m_mode);
        rs  = m_regen(m_ds[i], r, m_mode);
        k   = rs ? rd : m_sr[i][idx];
        exp_q[i] = k ^ (m_mode && m_dd[i] < 0) ^ (m_mode && m_ds[i] < 0);
        if (rs) begin
          for (int j = DEP - 1; j > 0; j--) m_sr[i][j] = m_sr[i][j-1];
          m_sr[i][0] = rd;
        end
        m_dd[i] = fix_range(m_dd[i] + (dividend[i] ? 1 : -1), m_mode);
        m_ds[i] = fix_range(m_ds[i] + (divisor[i] ? 1 : -1), m_mode);
      end
    end
  endtask

  // Apply the current inputs for one edge; outputs are settled when this returns.
  task automatic step();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    check("out_valid", int'(out_valid), int'(exp_v));
    check("quotient", int'(quotient), int'(exp_q));
  end

  task automatic rand_inputs();
    randNum       = CH*BW'($urandom);
    randNumKernel = CH*DEPLOG'($urandom);
    dividend      = CH'($urandom);
    divisor       = CH'($urandom);
  endtask

  int bias [CH];

  initial begin
    rst = 1'b1; bipolar = 1'b1; in_valid = 1'b1;
    rand_inputs();
    m_mode = 1'b1; exp_q = '0; exp_v = 1'b0;
    // Reset with arbitrary inputs
    step(); rand_inputs(); step();
    check("reset_quotient", int'(quotient), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_cnt", int'(dut.cnt_dd_q[1]), 0);

    // Lane0 pass-through
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rand_inputs();
      dividend[0] = 1'b1; divisor[0] = 1'b1; randNum[BW-1:0] = '0;
      step();
      if (c == 0) check("first_valid", int'(out_valid), 1);
    end
    check("pass_q0", int'(quotient[0]), 1);

    // Divisor gap on lane0: sr=11, divisor regen forced low
    for (int c = 0; c < 2; c++) begin
      rand_inputs();
      dividend[0] = 1'b1; divisor[0] = 1'b1; randNum[BW-1:0] = 8'd255;
      randNumKernel[0] = c[0];
      step();
      check("gap_q0", int'(quotient[0]), 1);
    end

    // Stall
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rand_inputs(); step();
      check("stall_valid", int'(out_valid), 0);
    end
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin rand_inputs(); step(); end

    // Long positive run: saturation or wrap-around
    rst = 1'b1; rand_inputs(); step(); rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      rand_inputs();
      dividend = '1; divisor = {CH{c[0] == 1'b0}}; randNum = '0;
      step();
    end
`ifdef CORDIV_IS_SAT_EN
    check("long_run_q", int'(quotient), 3);
`else
    check("long_run_q", int'(quotient), 0);
`endif

    // Mode switch bipolar -> unipolar with in_valid high
    for (int c = 0; c < 5; c++) begin rand_inputs(); step(); end
    bipolar = 1'b0; rand_inputs(); step();
    check("mode_out_valid", int'(out_valid), 0);
    check("mode_quotient", int'(quotient), 0);
    check("mode_cnt", int'(dut.cnt_dd_q[0]), 128);
    for (int c = 0; c < 5; c++) begin rand_inputs(); step(); end

    // Randomised run with biased streams, mode toggles, stalls and resets
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) for (int i = 0; i < CH; i++) bias[i] = int'($urandom_range(0, 100));
      rand_inputs();
      for (int i = 0; i < CH; i++) begin
        dividend[i] = ($urandom_range(0, 99) < bias[i]);
        divisor[i]  = ($urandom_range(0, 99) < 100 - bias[i]);
      end
      rst      = ($urandom_range(0, 399) == 0);
      in_valid = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 149) == 0) bipolar = ~bipolar;
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
